tt_gate_seq: RTL and testbench

TT_GATE_SEQ -- requirements
Module: tt_gate_seq

---
 rtl/tt_gate_pkg.sv | 18 +
 rtl/tt_lut_mux.sv | 14 +
 rtl/tt_gate_seq.sv | 166 ++++++++++++++++
 tb/tb_tt_gate_seq.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_gate_pkg.sv
// Shared types and helpers for the truth-table gate sequencer.
package tt_gate_pkg;

    // Default number of logic inputs feeding the truth table.
    localparam int NUM_IN_DEFAULT = 4;

    // Sweep controller states.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    // Number of truth-table entries for n logic inputs.
    function automatic int tt_width(input int n);
        return int'(32'd1 << n);
    endfunction

endpackage

// File: rtl/tt_lut_mux.sv
// Combinational truth-table lookup: selects entry idx_i of the table.
module tt_lut_mux
    import tt_gate_pkg::*;
#(
    parameter int NUM_IN = NUM_IN_DEFAULT
) (
    input  logic [tt_width(NUM_IN)-1:0] tt_i,
    input  logic [NUM_IN-1:0]           idx_i,
    output logic                        bit_o
);

    assign bit_o = tt_i[idx_i];

endmodule

// File: rtl/tt_gate_seq.sv
// Truth-table gate evaluator with valid/ready handshakes and an optional
// exhaustive sweep engine compiled in by the TT_GATE_SWEEP_EN macro.
// Without the macro the block is a pure streaming evaluator: busy is tied
// low and sweep_start only gates in_ready in the cycle it is asserted.
module tt_gate_seq
    import tt_gate_pkg::*;
#(
    parameter int                          NUM_IN   = NUM_IN_DEFAULT,
    parameter logic [tt_width(NUM_IN)-1:0] TT_RESET = 16'h3060
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_we,
    input  logic [tt_width(NUM_IN)-1:0] cfg_tt,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_IN-1:0]           in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_bit,
    output logic [NUM_IN-1:0]           out_idx,
    input  logic                        sweep_start,
    output logic                        busy
);

    localparam int TT_W = tt_width(NUM_IN);

`ifdef TT_GATE_SWEEP_EN
    // One extra counter bit so "all entries issued" never aliases index 0.
    localparam int               CNT_W    = NUM_IN + 1;
    localparam logic [NUM_IN:0]  CNT_END  = CNT_W'(TT_W);
    localparam logic [NUM_IN:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [NUM_IN:0]  CNT_ZERO = {CNT_W{1'b0}};

    logic [NUM_IN:0] cnt_q, cnt_d;
`endif

    logic [TT_W-1:0]   tt_q, tt_d;
    state_e            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic              out_bit_q, out_bit_d;
    logic [NUM_IN-1:0] out_idx_q, out_idx_d;

    logic              slot_free_s;
    logic              accept_s;
    logic [NUM_IN-1:0] lut_idx_s;
    logic              lut_bit_s;

    tt_lut_mux #(
        .NUM_IN (NUM_IN)
    ) u_lut_mux (
        .tt_i  (tt_q),
        .idx_i (lut_idx_s),
        .bit_o (lut_bit_s)
    );

    assign slot_free_s = !out_valid_q || out_ready;
    assign in_ready    = (state_q == IDLE) && slot_free_s && !sweep_start;
    assign accept_s    = in_valid && in_ready;

    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_idx   = out_idx_q;
`ifdef TT_GATE_SWEEP_EN
    assign busy      = (state_q == SWEEP);
`else
    assign busy      = 1'b0;
`endif

    // Next-state logic: table update, output slot and sweep sequencing.
    always_comb begin
        tt_d        = tt_q;
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_bit_d   = out_bit_q;
        out_idx_d   = out_idx_q;
        lut_idx_s   = in_data;
`ifdef TT_GATE_SWEEP_EN
        cnt_d       = cnt_q;
`endif

        // Table writes land next cycle; the lookup below still sees tt_q.
        if (cfg_we && (state_q == IDLE)) begin
            tt_d = cfg_tt;
        end else begin
            tt_d = tt_q;
        end

        // A consumed (or empty) slot frees up unless refilled below.
        if (slot_free_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (accept_s) begin
            out_valid_d = 1'b1;
            out_bit_d   = lut_bit_s;
            out_idx_d   = in_data;
        end else begin
            out_bit_d   = out_bit_q;
            out_idx_d   = out_idx_q;
        end

`ifdef TT_GATE_SWEEP_EN
        case (state_q)
            IDLE: begin
                if (sweep_start) begin
                    state_d = SWEEP;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = IDLE;
                end
            end
            SWEEP: begin
                lut_idx_s = cnt_q[NUM_IN-1:0];
                // Issue the next index only into a free slot; a pending
                // result from before the sweep drains first this way.
                if (slot_free_s && (cnt_q != CNT_END)) begin
                    out_valid_d = 1'b1;
                    out_bit_d   = lut_bit_s;
                    out_idx_d   = cnt_q[NUM_IN-1:0];
                    cnt_d       = cnt_q + CNT_ONE;
                end else begin
                    cnt_d       = cnt_q;
                end
                // Once everything is issued, the held result is the last index.
                if (out_valid_q && out_ready && (cnt_q == CNT_END)) begin
                    state_d = IDLE;
                end else begin
                    state_d = SWEEP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`else
        state_d = IDLE;
`endif
    end

    // State registers with synchronous reset that discards all work.
    always_ff @(posedge clk) begin
        if (rst) begin
            tt_q        <= TT_RESET;
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_idx_q   <= {NUM_IN{1'b0}};
`ifdef TT_GATE_SWEEP_EN
            cnt_q       <= CNT_ZERO;
`endif
        end else begin
            tt_q        <= tt_d;
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_idx_q   <= out_idx_d;
`ifdef TT_GATE_SWEEP_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_tt_gate_seq.sv
// Directed bench for tt_gate_seq (NUM_IN=4, default reset table 16'h3060).
// Sweep scenarios are exercised when TT_GATE_SWEEP_EN is defined; otherwise
// the disabled-sweep behaviour is checked.
module tb_tt_gate_seq;
    import tt_gate_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [15:0] cfg_tt;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_bit;
    logic [3:0]  out_idx;
    logic        sweep_start;
    logic        busy;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] tt_ref;

    typedef struct {
        logic [3:0] data;
        logic       exp_bit;
    } vec_t;

    vec_t vecs[8];

    tt_gate_seq #(
        .NUM_IN   (4),
        .TT_RESET (16'h3060)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_tt      (cfg_tt),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bit     (out_bit),
        .out_idx     (out_idx),
        .sweep_start (sweep_start),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single evaluation with out_ready high; result checked one cycle later.
    task automatic eval(input string nm, input logic [3:0] d, input logic e);
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b1;
        #1;
        chk({nm, "_in_ready"}, in_ready, 1);
        step();
        in_valid = 1'b0;
        chk({nm, "_valid"}, out_valid, 1);
        chk({nm, "_idx"}, out_idx, d);
        chk({nm, "_bit"}, out_bit, e);
        step();
    endtask

`ifdef TT_GATE_SWEEP_EN
    // mode 0: out_ready always high; mode 1: out_ready toggles.
    // pend >= 0: an output with that index is pending when the sweep starts.
    task automatic run_sweep(input int mode, input int pend, input bit cfg_mid);
        int         got;
        int         total;
        int         exp_idx;
        bit         stalled;
        logic       hb;
        logic [3:0] hi;
        total       = (pend >= 0) ? 17 : 16;
        out_ready   = 1'b0;
        sweep_start = 1'b1;
        #1;
        chk("sweep_gates_in_ready", in_ready, 0);
        step();
        sweep_start = 1'b0;
        chk("sweep_busy_rise", busy, 1);
        got     = 0;
        stalled = 1'b0;
        hb      = 1'b0;
        hi      = 4'h0;
        for (int cyc = 0; cyc < 100 && got < total; cyc++) begin
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            cfg_we    = cfg_mid && (cyc == 3);
            cfg_tt    = 16'hFFFF;
            if (stalled) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_bit", out_bit, hb);
                chk("stall_idx", out_idx, hi);
            end
            stalled = out_valid && !out_ready;
            hb      = out_bit;
            hi      = out_idx;
            if (out_valid && out_ready) begin
                exp_idx = (pend >= 0) ? ((got == 0) ? pend : got - 1) : got;
                chk("sweep_idx", out_idx, exp_idx);
                chk("sweep_bit", out_bit, tt_ref[exp_idx]);
                got++;
            end
            step();
        end
        cfg_we = 1'b0;
        chk("sweep_count", got, total);
        chk("sweep_busy_fall", busy, 0);
        chk("sweep_drained", out_valid, 0);
        out_ready = 1'b1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'h5, 1'b1};
        vecs[1] = '{4'h0, 1'b0};
        vecs[2] = '{4'hC, 1'b1};
        vecs[3] = '{4'h7, 1'b0};
        vecs[4] = '{4'h6, 1'b1};
        vecs[5] = '{4'hD, 1'b1};
        vecs[6] = '{4'hF, 1'b0};
        vecs[7] = '{4'h4, 1'b0};
        tt_ref  = 16'h3060;

        rst         = 1'b1;
        cfg_we      = 1'b0;
        cfg_tt      = 16'h0000;
        in_valid    = 1'b0;
        in_data     = 4'h0;
        out_ready   = 1'b1;
        sweep_start = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_bit", out_bit, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_busy", busy, 0);
        #1;
        chk("rst_in_ready", in_ready, 1);

        // Back-to-back stream through the reset table.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = vecs[i].data;
            #1;
            chk("tbl_in_ready", in_ready, 1);
            step();
            chk("tbl_valid", out_valid, 1);
            chk("tbl_idx", out_idx, vecs[i].data);
            chk("tbl_bit", out_bit, vecs[i].exp_bit);
        end
        in_valid = 1'b0;
        step();
        chk("tbl_idle_after", out_valid, 0);

        // Backpressure holds the result and blocks new input.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'h5;
        step();
        in_data = 4'h0;
        repeat (2) begin
            #1;
            chk("bp_in_ready", in_ready, 0);
            step();
            chk("bp_valid", out_valid, 1);
            chk("bp_idx", out_idx, 5);
            chk("bp_bit", out_bit, 1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("bp_next_idx", out_idx, 0);
        chk("bp_next_bit", out_bit, 0);
        step();

        // Table write: same-cycle input sees old table, next one the new.
        cfg_we   = 1'b1;
        cfg_tt   = 16'hFFFF;
        in_valid = 1'b1;
        in_data  = 4'h0;
        step();
        cfg_we = 1'b0;
        chk("cfg_old_table", out_bit, 0);
        step();
        in_valid = 1'b0;
        chk("cfg_new_table", out_bit, 1);
        step();
        cfg_we = 1'b1;
        cfg_tt = 16'h3060;
        step();
        cfg_we = 1'b0;
        eval("cfg_restored", 4'h0, 1'b0);

`ifdef TT_GATE_SWEEP_EN
        run_sweep(0, -1, 1'b0);
        run_sweep(1, -1, 1'b0);

        // Pending result drains before sweep index 0.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'hC;
        step();
        in_valid = 1'b0;
        run_sweep(0, 12, 1'b0);

        // Table write during a sweep is ignored.
        run_sweep(0, -1, 1'b1);
        eval("cfg_ignored_busy", 4'h0, 1'b0);

        // Reset mid-sweep restores the reset table and aborts the sweep.
        cfg_we = 1'b1;
        cfg_tt = 16'h00FF;
        step();
        cfg_we      = 1'b0;
        out_ready   = 1'b1;
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        begin
            bit found;
            found = 1'b0;
            for (int cyc = 0; cyc < 40 && !found; cyc++) begin
                if (out_valid && (out_idx == 4'h7)) begin
                    found = 1'b1;
                end else begin
                    step();
                end
            end
            chk("rst_sweep_reached_7", found, 1);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_sweep_valid", out_valid, 0);
        chk("rst_sweep_busy", busy, 0);
        eval("rst_sweep_table", 4'hC, 1'b1);
        run_sweep(0, -1, 1'b0);
`else
        // Sweep disabled: start pulse only gates in_ready in its own cycle.
        in_valid    = 1'b1;
        in_data     = 4'h5;
        out_ready   = 1'b1;
        sweep_start = 1'b1;
        #1;
        chk("nosweep_gate", in_ready, 0);
        step();
        sweep_start = 1'b0;
        chk("nosweep_busy", busy, 0);
        chk("nosweep_not_accepted", out_valid, 0);
        #1;
        chk("nosweep_ready_back", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("nosweep_valid", out_valid, 1);
        chk("nosweep_idx", out_idx, 5);
        chk("nosweep_bit", out_bit, 1);
        chk("nosweep_busy_after", busy, 0);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
